// File: rtl/rf_sched_pkg.sv
// Shared widths, FIFO geometry and entry/priority types for the register-file
// write-back scheduler.
package rf_sched_pkg;

  localparam int PW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  // Pointers wrap naturally because DEPTH is a power of two.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
    logic          flag;
    logic          flag_wr;
  } wr_entry_t;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LD  = 1'b1
  } prio_e;

endpackage

// File: rtl/rf_write_sched_if.sv
// Write-back request, register-file write and pending-write lookup signals
// shared between the execution units and the scheduler.
interface rf_write_sched_if #(
  parameter int PW = rf_sched_pkg::PW,
  parameter int DW = rf_sched_pkg::DW
);

  logic          alu_req;
  logic [PW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_flag;
  logic          alu_gnt;

  logic          ld_req;
  logic [PW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_gnt;

  logic          rf_hold;
  logic          rf_wr_en;
  logic [PW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat_in;
  logic          rf_flag;
  logic          rf_flag_wr;

  logic [PW-1:0] rd_addr;
  logic          rd_busy;
  logic [DW-1:0] rd_fwd_data;

  modport master (
    output alu_req, alu_addr, alu_data, alu_flag, input alu_gnt,
    output ld_req, ld_addr, ld_data, input ld_gnt,
    output rf_hold,
    input  rf_wr_en, rf_wr_addr, rf_dat_in, rf_flag, rf_flag_wr,
    output rd_addr, input rd_busy, rd_fwd_data
  );

  modport slave (
    input  alu_req, alu_addr, alu_data, alu_flag, output alu_gnt,
    input  ld_req, ld_addr, ld_data, output ld_gnt,
    input  rf_hold,
    output rf_wr_en, rf_wr_addr, rf_dat_in, rf_flag, rf_flag_wr,
    input  rd_addr, output rd_busy, rd_fwd_data
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// Small in-order write buffer; exposes every slot and its validity so the
// scheduler can search pending writes.
module rf_wr_fifo
  import rf_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  wr_entry_t                   push_ent,
  input  logic                        pop,
  output wr_entry_t                   head,
  output logic                        empty,
  output logic                        full,
  output wr_entry_t [DEPTH-1:0]       slots,
  output logic      [DEPTH-1:0]       slot_vld,
  output ptr_t                        head_idx
);

  wr_entry_t [DEPTH-1:0] mem;
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  cnt_t                  count;

  // NOTE: payload storage has no reset; validity comes only from count,
  // which is reset, so stale data can never be observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    // NOTE: assign a default before any loop/branch so no path infers a latch.
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = {1'b0, ptr_t'(i) - rd_ptr} < count;
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(DEPTH));
  assign head     = mem[rd_ptr];
  assign head_idx = rd_ptr;
  assign slots    = mem;

endmodule

// File: rtl/rf_write_sched.sv
// Round-robin write-back arbiter between ALU and load unit, feeding the
// register-file write port through a 2-entry buffer with pending-write lookup.
module rf_write_sched #(
  parameter int PW = rf_sched_pkg::PW,
  parameter int DW = rf_sched_pkg::DW
) (
  input logic              clk,
  input logic              reset,
  rf_write_sched_if.slave  bus
);

  import rf_sched_pkg::*;

  prio_e                 prio_q;
  prio_e                 prio_d;
  logic                  alu_gnt;
  logic                  ld_gnt;
  logic                  contest;
  logic                  pop;
  logic                  space;
  wr_entry_t             push_ent;
  wr_entry_t             head;
  logic                  empty;
  logic                  full;
  wr_entry_t [DEPTH-1:0] slots;
  logic      [DEPTH-1:0] slot_vld;
  ptr_t                  head_idx;
  ptr_t                  idx;
  logic                  busy;
  logic      [DW-1:0]    fwd;

  rf_wr_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (alu_gnt | ld_gnt),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .slots    (slots),
    .slot_vld (slot_vld),
    .head_idx (head_idx)
  );

  // A held head cannot drain, so a full buffer under hold blocks all grants.
  assign pop   = ~empty & ~bus.rf_hold;
  assign space = ~full | pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= PRIO_ALU;
    else       prio_q <= prio_d;
  end

  always_comb begin
    alu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    prio_d  = prio_q;
    contest = bus.alu_req & bus.ld_req;
    if (space && !reset) begin
      if (contest) begin
        // Winner hands priority to the loser for the next contest.
        if (prio_q == PRIO_ALU) begin
          alu_gnt = 1'b1;
          prio_d  = PRIO_LD;
        end else begin
          ld_gnt  = 1'b1;
          prio_d  = PRIO_ALU;
        end
      end else begin
        alu_gnt = bus.alu_req;
        ld_gnt  = bus.ld_req;
      end
    end
  end

  always_comb begin
    push_ent = '{addr: bus.ld_addr, data: bus.ld_data, flag: 1'b0, flag_wr: 1'b0};
    if (alu_gnt) begin
      push_ent = '{addr: bus.alu_addr, data: bus.alu_data, flag: bus.alu_flag, flag_wr: 1'b1};
    end
  end

  // Walk oldest to youngest so the youngest match wins the forward.
  always_comb begin
    busy = 1'b0;
    fwd  = '0;
    idx  = head_idx;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + ptr_t'(k);
      if (slot_vld[idx] && (slots[idx].addr == bus.rd_addr)) begin
        busy = 1'b1;
        fwd  = slots[idx].data;
      end
    end
  end

  assign bus.alu_gnt     = alu_gnt;
  assign bus.ld_gnt      = ld_gnt;
  assign bus.rf_wr_en    = pop;
  assign bus.rf_wr_addr  = empty ? '0 : head.addr;
  assign bus.rf_dat_in   = empty ? '0 : head.data;
  assign bus.rf_flag     = empty ? 1'b0 : head.flag;
  assign bus.rf_flag_wr  = pop & head.flag_wr;
  assign bus.rd_busy     = busy;
  assign bus.rd_fwd_data = fwd;

endmodule
